matrix_ops_engine: RTL
======================

Name: matrix_ops_engine

Overview:
- Parametrised, buffered matrix arithmetic engine that replaces the fixed 8-bit mat_ops datapath in the matrix calculator.
- Accepts operand matrices as element streams, holds them in internal buffers, computes one of four operations and streams the result in row-major order.
- Sits between matrix_storage (operand source) and uart_tx / seg_display (result sinks).
- Adds configurable element width, configurable maximum dimension, matrix multiply, dimension checking, and valid/ready backpressure on both streams.

Parameters:
- DATA_W, 8, operand element width (unsigned).
- MAX_DIM, 5, maximum rows/columns of any operand.
- DIM_W, $clog2(MAX_DIM+1), width of dimension ports.
- RES_W, 2*DATA_W+$clog2(MAX_DIM), result element width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; op and dims are sampled when it is accepted.
- op_sel  in  3  000 add A+B, 001 transpose A, 010 scalar k*A, 011 multiply A*B, 1xx invalid.
- dim_m  in  DIM_W  rows of A.
- dim_n  in  DIM_W  columns of A.
- dim_p  in  DIM_W  columns of B (add: must equal dim_n; multiply: B is dim_n x dim_p).
- scalar_k  in  DATA_W  multiplier for op 010.
- in_valid  in  1  operand element valid.
- in_ready  out  1  engine accepts an operand element.
- in_data  in  DATA_W  operand element: A row-major, then B row-major.
- out_valid  out  1  result element valid.
- out_ready  in  1  downstream accepts a result element.
- out_data  out  RES_W  result element, zero-extended.
- out_last  out  1  marks the final result element.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result handshake.
- error  out  1  one-cycle pulse when a start request is rejected.

Behaviour:
- Reset: all outputs are 0, the state is IDLE and all counters are 0. Buffer contents are not cleared. Reset in any state aborts the operation immediately.
- States: IDLE -> LOAD_A -> LOAD_B (ops 000/011 only) -> COMPUTE -> OUTPUT -> IDLE.
- IDLE:
  - start=1 with valid config: latch op, dims and k; go to LOAD_A next cycle.
  - Invalid config: error=1 the next cycle; remain in IDLE.
  - Invalid means any of: op 1xx; dim_m or dim_n equal to 0 or greater than MAX_DIM; for ops 000/011, dim_p equal to 0 or greater than MAX_DIM; for op 000, dim_p != dim_n.
- start outside IDLE is ignored. It causes no error.
- LOAD_A: in_ready=1. Each in_valid&&in_ready cycle stores one element. After dim_m*dim_n elements, go to LOAD_B or COMPUTE.
- LOAD_B: in_ready=1. B holds dim_n*dim_p elements for multiply and dim_m*dim_n elements for add.
- in_ready=0 in every other state. in_valid without ready is ignored and does not stall.
- COMPUTE: fills the result buffer, one write per cycle for elementwise ops.
  - add: R[i][j] = A[i][j] + B[i][j]. m*n cycles.
  - transpose: R[j][i] = A[i][j]; result is n x m. m*n cycles.
  - scalar: R[i][j] = k * A[i][j]. m*n cycles.
  - multiply: R[i][j] = sum over t of A[i][t]*B[t][j]; one MAC per cycle; result is m x p. m*p*n cycles.
- Arithmetic: unsigned, computed at RES_W, no saturation. RES_W is sufficient, so no overflow is possible.
- OUTPUT:
  - out_valid=1 from the first OUTPUT cycle. Elements are emitted row-major.
  - out_data and out_last are held stable while out_valid && !out_ready.
  - The pointer advances only on out_valid && out_ready.
  - out_last=1 only with the final element.
- After the final handshake: the next cycle has done=1, busy=0, out_valid=0 and state IDLE. A start in that same cycle is accepted.
- Latency: the first out_valid occurs 1 + (load handshakes) + (compute cycles) cycles after start. Stalls on in_valid add cycles one for one.

Test Plan:
- Multiply 2x2 by 2x2: A=1,2,3,4 and B=5,6,7,8 -> outputs 19,22,43,50, out_last on 50, done one cycle later. COMPUTE lasts exactly 8 cycles.
- Add 2x3 (dim_p=3), all A and B elements 255 (DATA_W=8) -> six outputs of 510, with no truncation.
- Transpose 2x3: A=1..6 -> outputs 1,4,2,5,3,6; no LOAD_B phase; in_ready drops after the 6th element.
- Scalar k=3 on 1x1 A=200 -> output 600. Then out_ready held low for 5 cycles -> out_valid and out_data=600 stay stable throughout.
- Reject cases, each -> error pulse, busy stays 0: dim_m=0; dim_n=6 (MAX_DIM=5); add with dim_p=2 and dim_n=3; op_sel=100.
- Assert rst in LOAD_B mid-stream -> next cycle busy=0 and in_ready=0. A fresh 1x1 add of 7+8 then returns 15.

Source files
------------

// File: rtl/matrix_ops_engine_if.sv
// Stream interface for matrix_ops_engine.
// Carries the operand element stream (host -> engine) and the result element
// stream (engine -> host), each with valid/ready flow control.
//   master : the host side; drives operands and accepts results
//   slave  : the engine side; accepts operands and drives results
interface matrix_ops_engine_if #(
    parameter int DATA_W = 8,
    parameter int RES_W  = 19
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  out_data;
    logic              out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/matrix_ops_engine.sv
// Buffered matrix arithmetic engine: loads operand A (and B for add/multiply)
// from an element stream, computes add / transpose / scalar / multiply into a
// result buffer, then streams the result row-major with valid/ready.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle request; op_sel/dims/scalar_k sampled in IDLE
//   op_sel          000 add, 001 transpose, 010 scalar, 011 multiply
//   dim_m/n/p       rows of A, columns of A, columns of B
//   scalar_k        multiplier for the scalar op
//   bus             operand and result streams (slave side)
//   busy/done/error status: not idle / finished pulse / rejected-start pulse
module matrix_ops_engine #(
    parameter int DATA_W  = 8,
    parameter int MAX_DIM = 5,
    parameter int DIM_W   = $clog2(MAX_DIM + 1),
    parameter int RES_W   = 2 * DATA_W + $clog2(MAX_DIM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2:0]         op_sel,
    input  logic [DIM_W-1:0]   dim_m,
    input  logic [DIM_W-1:0]   dim_n,
    input  logic [DIM_W-1:0]   dim_p,
    input  logic [DATA_W-1:0]  scalar_k,
    matrix_ops_engine_if.slave bus,
    output logic               busy,
    output logic               done,
    output logic               error
);
    localparam int CELLS = MAX_DIM * MAX_DIM;
    localparam int IDX_W = $clog2(CELLS + 1);

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, OUTPUT} state_t;

    state_t             state_r;
    logic [1:0]         op_r;
    logic [DIM_W-1:0]   m_r, n_r, p_r;
    logic [DATA_W-1:0]  k_r;
    logic [IDX_W-1:0]   a_total_r, r_total_r, b_total_r, cnt_r;
    logic [DIM_W-1:0]   i_r, j_r, t_r;
    logic [RES_W-1:0]   acc_r;
    logic               busy_r, in_ready_r, out_valid_r, out_last_r, done_r, error_r;
    logic [RES_W-1:0]   out_data_r;

    logic [DATA_W-1:0]  a_mem [CELLS];
    logic [DATA_W-1:0]  b_mem [CELLS];
    logic [RES_W-1:0]   r_mem [CELLS];

    logic [IDX_W-1:0]   a_idx_s, b_idx_s, w_idx_s, next_ptr_s;
    logic [RES_W-1:0]   prod_s, w_data_s;
    logic [DIM_W-1:0]   j_lim_s;
    logic               t_end_s, j_end_s, last_s, w_en_s;

    function automatic logic [IDX_W-1:0] mul_idx(input logic [DIM_W-1:0] a, input logic [DIM_W-1:0] b);
        return IDX_W'(a) * IDX_W'(b);
    endfunction

    function automatic logic [IDX_W-1:0] lin_idx(input logic [DIM_W-1:0] row,
                                                 input logic [DIM_W-1:0] stride,
                                                 input logic [DIM_W-1:0] col);
        return mul_idx(row, stride) + IDX_W'(col);
    endfunction

    function automatic logic dim_ok(input logic [DIM_W-1:0] d);
        return (d != DIM_W'(0)) && (d <= DIM_W'(MAX_DIM));
    endfunction

    // p only matters for add (must equal n) and multiply (columns of B).
    function automatic logic cfg_ok(input logic [2:0] op, input logic [DIM_W-1:0] m,
                                    input logic [DIM_W-1:0] n, input logic [DIM_W-1:0] p);
        logic needs_p;
        needs_p = (op[1:0] == 2'd0) || (op[1:0] == 2'd3);
        return !op[2] && dim_ok(m) && dim_ok(n) && (!needs_p || dim_ok(p))
               && !((op[1:0] == 2'd0) && (p != n));
    endfunction

    assign busy          = busy_r;
    assign done          = done_r;
    assign error         = error_r;
    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;

    // Compute datapath: addresses, element value and loop-end flags for the current step.
    // Elementwise ops walk (i, j) over m x n with t fixed at 0; multiply walks
    // (i, j, t) over m x p x n and writes a result only when t wraps.
    always_comb begin
        a_idx_s    = IDX_W'(0);
        b_idx_s    = IDX_W'(0);
        w_idx_s    = IDX_W'(0);
        prod_s     = RES_W'(0);
        w_data_s   = RES_W'(0);
        next_ptr_s = cnt_r + IDX_W'(1);
        if (op_r == 2'd3) begin
            j_lim_s  = p_r;
            t_end_s  = (t_r == n_r - DIM_W'(1));
            a_idx_s  = lin_idx(i_r, n_r, t_r);
            b_idx_s  = lin_idx(t_r, p_r, j_r);
            w_idx_s  = lin_idx(i_r, p_r, j_r);
            prod_s   = RES_W'(a_mem[a_idx_s]) * RES_W'(b_mem[b_idx_s]);
            w_data_s = acc_r + prod_s;
        end else begin
            j_lim_s  = n_r;
            t_end_s  = 1'b1;
            a_idx_s  = lin_idx(i_r, n_r, j_r);
            b_idx_s  = a_idx_s;
            // transpose writes element (i,j) of A to row j, column i of an n x m result
            w_idx_s  = (op_r == 2'd1) ? lin_idx(j_r, m_r, i_r) : a_idx_s;
            prod_s   = RES_W'(k_r) * RES_W'(a_mem[a_idx_s]);
            case (op_r)
                2'd0:    w_data_s = RES_W'(a_mem[a_idx_s]) + RES_W'(b_mem[b_idx_s]);
                2'd1:    w_data_s = RES_W'(a_mem[a_idx_s]);
                2'd2:    w_data_s = prod_s;
                default: w_data_s = RES_W'(0);
            endcase
        end
        j_end_s = (j_r == j_lim_s - DIM_W'(1));
        last_s  = t_end_s && j_end_s && (i_r == m_r - DIM_W'(1));
        w_en_s  = (state_r == COMPUTE) && t_end_s;
    end

    // Operand capture: one element per accepted input handshake.
    always_ff @(posedge clk) begin
        if (!rst && in_ready_r && bus.in_valid) begin
            if (state_r == LOAD_A) a_mem[cnt_r] <= bus.in_data;
            else                   b_mem[cnt_r] <= bus.in_data;
        end
    end

    // Result buffer write, one element per completed compute step.
    always_ff @(posedge clk) begin
        if (!rst && w_en_s) r_mem[w_idx_s] <= w_data_s;
    end

    // Control FSM with registered status and stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            op_r        <= 2'd0;
            m_r         <= DIM_W'(0);
            n_r         <= DIM_W'(0);
            p_r         <= DIM_W'(0);
            k_r         <= DATA_W'(0);
            a_total_r   <= IDX_W'(0);
            b_total_r   <= IDX_W'(0);
            r_total_r   <= IDX_W'(0);
            cnt_r       <= IDX_W'(0);
            i_r         <= DIM_W'(0);
            j_r         <= DIM_W'(0);
            t_r         <= DIM_W'(0);
            acc_r       <= RES_W'(0);
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= RES_W'(0);
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok(op_sel, dim_m, dim_n, dim_p)) begin
                            op_r       <= op_sel[1:0];
                            m_r        <= dim_m;
                            n_r        <= dim_n;
                            p_r        <= dim_p;
                            k_r        <= scalar_k;
                            a_total_r  <= mul_idx(dim_m, dim_n);
                            b_total_r  <= (op_sel[1:0] == 2'd3) ? mul_idx(dim_n, dim_p) : mul_idx(dim_m, dim_n);
                            r_total_r  <= (op_sel[1:0] == 2'd3) ? mul_idx(dim_m, dim_p) : mul_idx(dim_m, dim_n);
                            cnt_r      <= IDX_W'(0);
                            i_r        <= DIM_W'(0);
                            j_r        <= DIM_W'(0);
                            t_r        <= DIM_W'(0);
                            acc_r      <= RES_W'(0);
                            busy_r     <= 1'b1;
                            in_ready_r <= 1'b1;
                            state_r    <= LOAD_A;
                        end else begin
                            error_r <= 1'b1;
                        end
                    end
                end
                LOAD_A: begin
                    if (bus.in_valid) begin
                        if (cnt_r == a_total_r - IDX_W'(1)) begin
                            cnt_r <= IDX_W'(0);
                            if (op_r == 2'd0 || op_r == 2'd3) begin
                                state_r <= LOAD_B;
                            end else begin
                                state_r    <= COMPUTE;
                                in_ready_r <= 1'b0;
                            end
                        end else begin
                            cnt_r <= next_ptr_s;
                        end
                    end
                end
                LOAD_B: begin
                    if (bus.in_valid) begin
                        if (cnt_r == b_total_r - IDX_W'(1)) begin
                            cnt_r      <= IDX_W'(0);
                            state_r    <= COMPUTE;
                            in_ready_r <= 1'b0;
                        end else begin
                            cnt_r <= next_ptr_s;
                        end
                    end
                end
                COMPUTE: begin
                    if (t_end_s) begin
                        t_r   <= DIM_W'(0);
                        acc_r <= RES_W'(0);
                        if (j_end_s) begin
                            j_r <= DIM_W'(0);
                            i_r <= i_r + DIM_W'(1);
                        end else begin
                            j_r <= j_r + DIM_W'(1);
                        end
                    end else begin
                        t_r   <= t_r + DIM_W'(1);
                        acc_r <= w_data_s;
                    end
                    if (last_s) begin
                        // The final write lands on the last result slot, so slot 0 is
                        // already in the buffer unless the result is a single element.
                        state_r     <= OUTPUT;
                        out_valid_r <= 1'b1;
                        out_data_r  <= (r_total_r == IDX_W'(1)) ? w_data_s : r_mem[0];
                        out_last_r  <= (r_total_r == IDX_W'(1));
                        cnt_r       <= IDX_W'(0);
                    end
                end
                OUTPUT: begin
                    if (bus.out_ready) begin
                        if (cnt_r == r_total_r - IDX_W'(1)) begin
                            state_r     <= IDLE;
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                            cnt_r       <= IDX_W'(0);
                        end else begin
                            cnt_r      <= next_ptr_s;
                            out_data_r <= r_mem[next_ptr_s];
                            out_last_r <= (next_ptr_s == r_total_r - IDX_W'(1));
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                    in_ready_r  <= 1'b0;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule
